// File: rtl/sa_sep_if_pkg.sv
// Shared defaults and index helpers for the separable switch allocator.
package sa_pkg;

  localparam int unsigned P_DEF = 5;
  localparam int unsigned V_DEF = 4;

  // Index width for an n-entry selector, never below one bit
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Flat position of VC v of input i
  function automatic int unsigned vc_idx(input int unsigned i, input int unsigned v,
                                         input int unsigned nv);
    return i * nv + v;
  endfunction

  // Base bit of the np-wide field belonging to entry k
  function automatic int unsigned port_field(input int unsigned k, input int unsigned np);
    return k * np;
  endfunction

endpackage

// File: rtl/sa_sep_if_rr_arbiter.sv
// Round-robin arbiter: grant is combinational, pointer moves past the winner only on upd_en.
module rr_arbiter
  import sa_pkg::*;
#(
  parameter int unsigned N = 4
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic [N-1:0] req,
  input  logic         upd_en,
  output logic [N-1:0] gnt
);

  localparam int unsigned PTRW = idx_w(N);

  logic [PTRW-1:0] ptr;
  logic [PTRW-1:0] gnt_idx;
  logic [PTRW-1:0] idx;
  logic            found;

  // Pick the first request at or after the pointer, wrapping at N
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    idx     = '0;
    found   = 1'b0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = PTRW'((32'(ptr) + k) % N);
      if (!found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        gnt_idx  = idx;
      end
    end
  end

  // Advance the pointer to one past the winner when the grant is accepted
  always_ff @(posedge clk) begin
    if (!rstn) begin
      ptr <= '0;
    end else if (upd_en && (|gnt)) begin
      ptr <= (gnt_idx == PTRW'(N - 1)) ? '0 : gnt_idx + PTRW'(1);
    end
  end

endmodule

// File: rtl/sa_sep_if.sv
// Separable input-first switch allocator, P ports x V VCs, iSLIP-style pointer update.
// Optional packet-level output locking is enabled by defining SA_PKT_LOCK_EN.
module sa_sep_if
  import sa_pkg::*;
#(
  parameter int unsigned P = P_DEF,
  parameter int unsigned V = V_DEF
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [P*V-1:0]   req_vc,
  input  logic [P*V*P-1:0] req_outport,
  input  logic [P*V-1:0]   req_tail,
  output logic [P*V-1:0]   grant_vc,
  output logic [P-1:0]     grant_in,
  output logic [P*P-1:0]   sel_in_for_out,
  output logic [P*P-1:0]   sel_out_for_in
);

  logic [P-1:0][V-1:0] s1_req;
  logic [P-1:0][V-1:0] s1_gnt;
  logic [P-1:0][P-1:0] s1_out;   // [input][output] request forwarded by stage 1
  logic [P-1:0][P-1:0] s2_req;   // [output][input]
  logic [P-1:0][P-1:0] s2_gnt;   // [output][input]
  logic [P*V-1:0]      vc_ok;    // VC not blocked by another packet's lock

`ifdef SA_PKT_LOCK_EN
  localparam int unsigned PW = idx_w(P);
  localparam int unsigned VW = idx_w(V);

  logic [P-1:0]         lock_vld,     lock_vld_nxt;
  logic [P-1:0][PW-1:0] lock_in,      lock_in_nxt;
  logic [P-1:0][VW-1:0] lock_vc,      lock_vc_nxt;

  // Block every VC aiming at a locked output unless it owns the lock
  always_comb begin
    vc_ok = '1;
    for (int unsigned i = 0; i < P; i++) begin
      for (int unsigned v = 0; v < V; v++) begin
        for (int unsigned o = 0; o < P; o++) begin
          if (req_outport[port_field(vc_idx(i, v, V), P) + o] && lock_vld[o] &&
              ((lock_in[o] != PW'(i)) || (lock_vc[o] != VW'(v)))) begin
            vc_ok[vc_idx(i, v, V)] = 1'b0;
          end
        end
      end
    end
  end

  // Non-tail grant claims the output for its packet, tail grant releases it
  always_comb begin
    lock_vld_nxt = lock_vld;
    lock_in_nxt  = lock_in;
    lock_vc_nxt  = lock_vc;
    for (int unsigned o = 0; o < P; o++) begin
      for (int unsigned i = 0; i < P; i++) begin
        for (int unsigned v = 0; v < V; v++) begin
          if (s2_gnt[o][i] && s1_gnt[i][v]) begin
            if (req_tail[vc_idx(i, v, V)]) begin
              lock_vld_nxt[o] = 1'b0;
            end else begin
              lock_vld_nxt[o] = 1'b1;
              lock_in_nxt[o]  = PW'(i);
              lock_vc_nxt[o]  = VW'(v);
            end
          end
        end
      end
    end
  end

  // Lock state register
  always_ff @(posedge clk) begin
    if (!rstn) begin
      lock_vld <= '0;
      lock_in  <= '0;
      lock_vc  <= '0;
    end else begin
      lock_vld <= lock_vld_nxt;
      lock_in  <= lock_in_nxt;
      lock_vc  <= lock_vc_nxt;
    end
  end
`else
  logic unused_tail;
  assign unused_tail = ^req_tail;
  assign vc_ok       = '1;
`endif

  // Eligible VC requests: valid, aimed somewhere, not lock-blocked, not in reset
  always_comb begin
    s1_req = '0;
    for (int unsigned i = 0; i < P; i++) begin
      for (int unsigned v = 0; v < V; v++) begin
        s1_req[i][v] = rstn & req_vc[vc_idx(i, v, V)] & vc_ok[vc_idx(i, v, V)] &
                       (|req_outport[port_field(vc_idx(i, v, V), P) +: P]);
      end
    end
  end

  // Forward each stage-1 winner's target and build per-output request columns
  always_comb begin
    s1_out = '0;
    s2_req = '0;
    for (int unsigned i = 0; i < P; i++) begin
      for (int unsigned v = 0; v < V; v++) begin
        if (s1_gnt[i][v]) begin
          s1_out[i] = s1_out[i] | req_outport[port_field(vc_idx(i, v, V), P) +: P];
        end
      end
    end
    for (int unsigned o = 0; o < P; o++) begin
      for (int unsigned i = 0; i < P; i++) begin
        s2_req[o][i] = s1_out[i][o];
      end
    end
  end

  for (genvar g = 0; g < P; g++) begin : g_arb
    rr_arbiter #(.N(V)) u_s1 (
      .clk    (clk),
      .rstn   (rstn),
      .req    (s1_req[g]),
      .upd_en (grant_in[g]),
      .gnt    (s1_gnt[g])
    );

    rr_arbiter #(.N(P)) u_s2 (
      .clk    (clk),
      .rstn   (rstn),
      .req    (s2_req[g]),
      .upd_en (|s2_gnt[g]),
      .gnt    (s2_gnt[g])
    );
  end

  // Grant matrix, its transpose, and VC grants gated by stage-2 success
  always_comb begin
    sel_in_for_out = '0;
    sel_out_for_in = '0;
    grant_in       = '0;
    grant_vc       = '0;
    for (int unsigned o = 0; o < P; o++) begin
      for (int unsigned i = 0; i < P; i++) begin
        sel_in_for_out[port_field(o, P) + i] = s2_gnt[o][i];
        sel_out_for_in[port_field(i, P) + o] = s2_gnt[o][i];
        if (s2_gnt[o][i]) begin
          grant_in[i] = 1'b1;
        end
      end
    end
    for (int unsigned i = 0; i < P; i++) begin
      grant_vc[vc_idx(i, 0, V) +: V] = s1_gnt[i] & {V{grant_in[i]}};
    end
  end

  // Requests name at most one output; grant matrix stays zero/one-hot
  always_ff @(posedge clk) begin
    if (rstn) begin
      for (int unsigned k = 0; k < P * V; k++) begin
        assert (!req_vc[k] || $onehot0(req_outport[port_field(k, P) +: P]));
      end
      for (int unsigned o = 0; o < P; o++) begin
        assert ($onehot0(sel_in_for_out[port_field(o, P) +: P]));
        assert ($onehot0(sel_out_for_in[port_field(o, P) +: P]));
      end
    end
  end

endmodule

// File: tb/tb_sa_sep_if.sv
// Bench for sa_sep_if: directed vector table, lock sequence (SA_PKT_LOCK_EN), random vs model.
module tb_sa_sep_if;

  localparam int P  = 5;
  localparam int V  = 4;
  localparam int NV = P * V;
`ifdef SA_PKT_LOCK_EN
  localparam bit LOCK = 1'b1;
`else
  localparam bit LOCK = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rstn;
  logic [NV-1:0]     req_vc;
  logic [NV*P-1:0]   req_outport;
  logic [NV-1:0]     req_tail;
  logic [NV-1:0]     grant_vc;
  logic [P-1:0]      grant_in;
  logic [P*P-1:0]    sel_in_for_out;
  logic [P*P-1:0]    sel_out_for_in;

  sa_sep_if #(.P(P), .V(V)) dut (
    .clk            (clk),
    .rstn           (rstn),
    .req_vc         (req_vc),
    .req_outport    (req_outport),
    .req_tail       (req_tail),
    .grant_vc       (grant_vc),
    .grant_in       (grant_in),
    .sel_in_for_out (sel_in_for_out),
    .sel_out_for_in (sel_out_for_in)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit                r;
    logic [NV-1:0]     vc;
    logic [NV*P-1:0]   op;
    logic [NV-1:0]     tl;
    logic [NV-1:0]     gvc;
    logic [P-1:0]      gin;
    logic [P*P-1:0]    sio;
    logic [P*P-1:0]    soi;
  } vec_t;

  int checks   = 0;
  int failures = 0;

  // Reference model state: pointers and locks as plain integers
  int ip_ptr [P];
  int op_ptr [P];
  bit lk_vld [P];
  int lk_in  [P];
  int lk_vc  [P];
  int s1_win [P];
  int win_in [P];
  logic [NV-1:0]  exp_gvc;
  logic [P-1:0]   exp_gin;
  logic [P*P-1:0] exp_sio;
  logic [P*P-1:0] exp_soi;

  function automatic logic [NV*P-1:0] fld(int k, int o);
    logic [NV*P-1:0] r;
    r = '0;
    r[k*P+o] = 1'b1;
    return r;
  endfunction

  function automatic vec_t mk(bit r, logic [NV-1:0] vc, logic [NV*P-1:0] op,
                              logic [NV-1:0] tl, logic [NV-1:0] gvc, logic [P-1:0] gin,
                              logic [P*P-1:0] sio, logic [P*P-1:0] soi);
    vec_t e;
    e.r = r; e.vc = vc; e.op = op; e.tl = tl;
    e.gvc = gvc; e.gin = gin; e.sio = sio; e.soi = soi;
    return e;
  endfunction

  function automatic int target(int k);
    for (int o = 0; o < P; o++) if (req_outport[k*P+o]) return o;
    return -1;
  endfunction

  task automatic check(string name, logic [127:0] got, logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  // Input-first separable allocation computed straight from the rules
  task automatic model_eval();
    exp_gvc = '0; exp_gin = '0; exp_sio = '0; exp_soi = '0;
    for (int i = 0; i < P; i++) begin s1_win[i] = -1; win_in[i] = -1; end
    if (rstn) begin
      for (int i = 0; i < P; i++) begin
        for (int n = 0; n < V; n++) begin
          int v, k, t;
          v = (ip_ptr[i] + n) % V;
          k = i * V + v;
          t = target(k);
          if (req_vc[k] && t >= 0 &&
              !(LOCK && lk_vld[t] && !(lk_in[t] == i && lk_vc[t] == v))) begin
            s1_win[i] = v;
            break;
          end
        end
      end
      for (int o = 0; o < P; o++) begin
        for (int n = 0; n < P; n++) begin
          int i;
          i = (op_ptr[o] + n) % P;
          if (s1_win[i] >= 0 && target(i * V + s1_win[i]) == o) begin
            win_in[o] = i;
            break;
          end
        end
      end
      for (int o = 0; o < P; o++) begin
        if (win_in[o] >= 0) begin
          exp_sio[o*P+win_in[o]] = 1'b1;
          exp_soi[win_in[o]*P+o] = 1'b1;
          exp_gin[win_in[o]]     = 1'b1;
          exp_gvc[win_in[o]*V+s1_win[win_in[o]]] = 1'b1;
        end
      end
    end
  endtask

  task automatic model_update();
    if (!rstn) begin
      for (int i = 0; i < P; i++) begin
        ip_ptr[i] = 0; op_ptr[i] = 0; lk_vld[i] = 1'b0; lk_in[i] = 0; lk_vc[i] = 0;
      end
    end else begin
      for (int o = 0; o < P; o++) begin
        if (win_in[o] >= 0) begin
          int i, v;
          i = win_in[o];
          v = s1_win[i];
          op_ptr[o] = (i + 1) % P;
          ip_ptr[i] = (v + 1) % V;
          if (LOCK) begin
            if (req_tail[i*V+v]) lk_vld[o] = 1'b0;
            else begin lk_vld[o] = 1'b1; lk_in[o] = i; lk_vc[o] = v; end
          end
        end
      end
    end
  endtask

  // One clock: drive, sample at negedge, compare, advance model at posedge
  task automatic run_cycle(vec_t e, bit use_tbl, string tag);
    bit inv_ok;
    rstn = e.r; req_vc = e.vc; req_outport = e.op; req_tail = e.tl;
    @(negedge clk);
    model_eval();
    if (use_tbl) begin
      check({tag, ".grant_vc"}, grant_vc, e.gvc);
      check({tag, ".grant_in"}, grant_in, e.gin);
      check({tag, ".sel_in_for_out"}, sel_in_for_out, e.sio);
      check({tag, ".sel_out_for_in"}, sel_out_for_in, e.soi);
    end else begin
      check({tag, ".grant_vc"}, grant_vc, exp_gvc);
      check({tag, ".grant_in"}, grant_in, exp_gin);
      check({tag, ".sel_in_for_out"}, sel_in_for_out, exp_sio);
      check({tag, ".sel_out_for_in"}, sel_out_for_in, exp_soi);
      inv_ok = 1'b1;
      for (int o = 0; o < P; o++) begin
        logic [P-1:0] col, row;
        col = sel_in_for_out[o*P +: P];
        row = sel_out_for_in[o*P +: P];
        if (!$onehot0(col) || !$onehot0(row)) inv_ok = 1'b0;
      end
      check({tag, ".onehot"}, 128'(inv_ok), 128'(1));
    end
    @(posedge clk);
    model_update();
    #1;
  endtask

  vec_t tbl[$];

  initial begin
    logic [NV*P-1:0] all_op, op_a, op_b, op_c, op_d, op_l;
    vec_t rst_e, e;

    for (int i = 0; i < P; i++) begin
      ip_ptr[i] = 0; op_ptr[i] = 0; lk_vld[i] = 1'b0; lk_in[i] = 0; lk_vc[i] = 0;
    end
    all_op = '0;
    for (int k = 0; k < NV; k++) all_op = all_op | fld(k, k % P);
    op_a = fld(0, 2) | fld(1, 2) | fld(2, 2) | fld(3, 2);
    op_b = fld(0, 4) | fld(4, 4) | fld(12, 4);
    op_c = fld(0, 0) | fld(4, 0) | fld(5, 3);
    op_d = fld(0, 1) | fld(4, 1) | fld(8, 1) | fld(12, 1) | fld(16, 1) | fld(11, 4);
    rst_e = mk(1'b0, '0, '0, '1, '0, '0, '0, '0);

    // Reset with busy requests, then idle release
    tbl.push_back(mk(1'b0, '1, all_op, '1, '0, '0, '0, '0));
    tbl.push_back(mk(1'b0, '1, all_op, '1, '0, '0, '0, '0));
    tbl.push_back(mk(1'b1, '0, all_op, '1, '0, '0, '0, '0));
    // Stage-1 fairness: input 0, VCs 0..3 -> out 2
    tbl.push_back(mk(1'b1, 20'hF, op_a, '1, 20'h1, 5'h1, 25'h400, 25'h4));
    tbl.push_back(mk(1'b1, 20'hF, op_a, '1, 20'h2, 5'h1, 25'h400, 25'h4));
    tbl.push_back(mk(1'b1, 20'hF, op_a, '1, 20'h4, 5'h1, 25'h400, 25'h4));
    tbl.push_back(mk(1'b1, 20'hF, op_a, '1, 20'h8, 5'h1, 25'h400, 25'h4));
    tbl.push_back(mk(1'b1, 20'hF, op_a, '1, 20'h1, 5'h1, 25'h400, 25'h4));
    tbl.push_back(rst_e);
    // Stage-2 fairness: inputs 0,1,3 VC0 -> out 4
    tbl.push_back(mk(1'b1, 20'h1011, op_b, '1, 20'h1,    5'h01, 25'h100000, 25'h10));
    tbl.push_back(mk(1'b1, 20'h1011, op_b, '1, 20'h10,   5'h02, 25'h200000, 25'h200));
    tbl.push_back(mk(1'b1, 20'h1011, op_b, '1, 20'h1000, 5'h08, 25'h800000, 25'h80000));
    tbl.push_back(mk(1'b1, 20'h1011, op_b, '1, 20'h1,    5'h01, 25'h100000, 25'h10));
    tbl.push_back(rst_e);
    // iSLIP hold: input 1 loses out 0, keeps its VC pointer
    tbl.push_back(mk(1'b1, 20'h11, op_c, '1, 20'h1,  5'h1, 25'h1,     25'h1));
    tbl.push_back(mk(1'b1, 20'h31, op_c, '1, 20'h10, 5'h2, 25'h2,     25'h20));
    tbl.push_back(mk(1'b1, 20'h31, op_c, '1, 20'h21, 5'h3, 25'h10001, 25'h101));
    tbl.push_back(rst_e);
    // Conflict matrix: all inputs -> out 1, input 2 VC3 -> out 4
    tbl.push_back(mk(1'b1, 20'h11911, op_d, '1, 20'h1,    5'h01, 25'h20,     25'h2));
    tbl.push_back(mk(1'b1, 20'h11911, op_d, '1, 20'h10,   5'h02, 25'h40,     25'h40));
    tbl.push_back(mk(1'b1, 20'h11911, op_d, '1, 20'h100,  5'h04, 25'h80,     25'h800));
    tbl.push_back(mk(1'b1, 20'h11911, op_d, '1, 20'h1800, 5'h0C, 25'h400100, 25'h14000));

    foreach (tbl[n]) run_cycle(tbl[n], 1'b1, $sformatf("vec%0d", n));

`ifdef SA_PKT_LOCK_EN
    // Packet lock: input 0 VC2 head/body/tail to out 1 against input 3 VC0
    op_l = fld(2, 1) | fld(12, 1);
    run_cycle(rst_e, 1'b1, "lock_rst");
    run_cycle(mk(1'b1, 20'h1004, op_l, 20'h1000, 20'h4,    5'h1, 25'h20,  25'h2),     1'b1, "lock_head");
    run_cycle(mk(1'b1, 20'h1004, op_l, 20'h1000, 20'h4,    5'h1, 25'h20,  25'h2),     1'b1, "lock_body");
    run_cycle(mk(1'b1, 20'h1004, op_l, 20'h1004, 20'h4,    5'h1, 25'h20,  25'h2),     1'b1, "lock_tail");
    run_cycle(mk(1'b1, 20'h1004, op_l, 20'h1000, 20'h1000, 5'h8, 25'h100, 25'h10000), 1'b1, "lock_after");
    run_cycle(mk(1'b1, 20'h1004, op_l, 20'h1000, 20'h4,    5'h1, 25'h20,  25'h2),     1'b1, "lock_head2");
    run_cycle(mk(1'b0, 20'h1004, op_l, 20'h1000, '0,       '0,   '0,      '0),        1'b1, "lock_midrst");
    run_cycle(mk(1'b1, 20'h1000, op_l, 20'h1000, 20'h1000, 5'h8, 25'h100, 25'h10000), 1'b1, "lock_postrst");
`else
    op_l = '0;
`endif

    // Random traffic against the reference model
    run_cycle(rst_e, 1'b0, "rnd_rst");
    for (int c = 0; c < 600; c++) begin
      e = rst_e;
      e.r = ($urandom_range(0, 49) != 0);
      e.op = op_l;
      for (int k = 0; k < NV; k++) begin
        int t;
        e.vc[k] = ($urandom_range(0, 2) == 0);
        e.tl[k] = ($urandom_range(0, 1) == 1);
        t = $urandom_range(0, P);
        e.op[k*P +: P] = '0;
        if (t < P) e.op[k*P+t] = 1'b1;
      end
      run_cycle(e, 1'b0, $sformatf("rnd%0d", c));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
